// File: rtl/hazard_ctrl_v2_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_v2_if
// Bundle of every datapath <-> hazard-unit signal of the 5-stage MIPS core.
//   master : datapath side. Drives stage register numbers, write/load flags,
//            bus-busy, divider-busy, branch and exception status. Receives
//            stall/flush/forward controls and the PC redirect.
//   slave  : hazard unit side, with the opposite directions.
// Parameters: RAW (register-address width), CNT_W (stall counter width).
// ---------------------------------------------------------------------------
interface hazard_ctrl_v2_if #(
    parameter int RAW   = 5,
    parameter int CNT_W = 32
);
    // memory-bus busy flags
    logic             i_stall;
    logic             d_stall;
    // register numbers per stage
    logic [RAW-1:0]   rsD, rtD;
    logic [RAW-1:0]   rsE, rtE;
    logic [RAW-1:0]   writeregE, writeregM, writeregW;
    logic             regwriteE, regwriteM, regwriteW;
    logic             memtoregE, memtoregM;
    // pipeline status
    logic             stall_divE;
    logic             branch_takenM;
    logic             except_logicM;
    logic [31:0]      excepttypeM;
    logic [31:0]      cp0_epcM;
    // controls back to the datapath
    logic             stallF, stallD, stallE, stallM, stallW;
    logic             flushD, flushE, flushM, flushW;
    logic [1:0]       forwardaE, forwardbE;
    logic             forwardaD, forwardbD;
    logic             pc_redirect;
    logic [31:0]      newpc;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output i_stall, d_stall,
        output rsD, rtD, rsE, rtE,
        output writeregE, writeregM, writeregW,
        output regwriteE, regwriteM, regwriteW,
        output memtoregE, memtoregM,
        output stall_divE, branch_takenM, except_logicM,
        output excepttypeM, cp0_epcM,
        input  stallF, stallD, stallE, stallM, stallW,
        input  flushD, flushE, flushM, flushW,
        input  forwardaE, forwardbE, forwardaD, forwardbD,
        input  pc_redirect, newpc, stall_cycles
    );

    modport slave (
        input  i_stall, d_stall,
        input  rsD, rtD, rsE, rtE,
        input  writeregE, writeregM, writeregW,
        input  regwriteE, regwriteM, regwriteW,
        input  memtoregE, memtoregM,
        input  stall_divE, branch_takenM, except_logicM,
        input  excepttypeM, cp0_epcM,
        output stallF, stallD, stallE, stallM, stallW,
        output flushD, flushE, flushM, flushW,
        output forwardaE, forwardbE, forwardaD, forwardbD,
        output pc_redirect, newpc, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_v2.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_v2
// Hazard/control unit for the 5-stage MIPS pipeline.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   hz   : hazard_ctrl_v2_if.slave - stage register numbers and status in,
//          stall/flush/forward selects, PC redirect and stall counter out.
// Functions: E-stage forwarding (M over W), D-stage branch forwarding from M,
// load-use bubbles (LOAD_LAT deep), divider stall, branch flush, full freeze
// while either memory bus is busy, exception redirect (deferred until the
// bus is idle), and a saturating count of cycles with stallF asserted.
// ---------------------------------------------------------------------------
module hazard_ctrl_v2 #(
    parameter int          RAW      = 5,
    parameter logic [31:0] EXC_VEC  = 32'hBFC00380,
    parameter int          LOAD_LAT = 1,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_v2_if.slave   hz
);

    typedef enum logic {
        ST_RUN,
        ST_WAIT_MEM
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pend_pc;
    logic [CNT_W-1:0] r_stall_cycles;

    logic             w_mem_busy;
    logic [31:0]      w_exc_target;
    logic             w_lw_e;
    logic             w_lw_m;
    logic             w_lwstall;
    logic             w_wait;
    logic             w_redirect;
    logic [31:0]      w_newpc;
    logic             w_stallF, w_stallD, w_stallE, w_stallM, w_stallW;
    logic             w_flushD, w_flushE, w_flushM, w_flushW;
    logic [1:0]       w_fwdaE, w_fwdbE;
    logic             w_fwdaD, w_fwdbD;

    assign w_mem_busy   = hz.i_stall | hz.d_stall;
    assign w_exc_target = (hz.excepttypeM == 32'h0000_000E) ? hz.cp0_epcM : EXC_VEC;

    // A pending exception is forgotten the moment reset is asserted, so the
    // redirect path must not see WAIT_MEM during the reset cycle itself.
    assign w_wait = (r_state == ST_WAIT_MEM) && !rst;

    // ---------------------------------------------------------------- forwarding
    always_comb begin
        w_fwdaE = 2'b00;
        w_fwdbE = 2'b00;
        if (hz.rsE != '0 && hz.rsE == hz.writeregM && hz.regwriteM)
            w_fwdaE = 2'b10;
        else if (hz.rsE != '0 && hz.rsE == hz.writeregW && hz.regwriteW)
            w_fwdaE = 2'b01;
        if (hz.rtE != '0 && hz.rtE == hz.writeregM && hz.regwriteM)
            w_fwdbE = 2'b10;
        else if (hz.rtE != '0 && hz.rtE == hz.writeregW && hz.regwriteW)
            w_fwdbE = 2'b01;
    end

    // A load result is not yet available in M, so branch compares only
    // forward ALU results.
    assign w_fwdaD = (hz.rsD != '0) && (hz.rsD == hz.writeregM) && hz.regwriteM && !hz.memtoregM;
    assign w_fwdbD = (hz.rtD != '0) && (hz.rtD == hz.writeregM) && hz.regwriteM && !hz.memtoregM;

    // ------------------------------------------------------------- load-use
    assign w_lw_e = hz.memtoregE && hz.regwriteE && (hz.writeregE != '0) &&
                    (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD);

    // With two-deep load latency the load still blocks its consumer while in M.
    generate
        if (LOAD_LAT >= 2) begin : g_lw_m
            assign w_lw_m = hz.memtoregM && (hz.writeregM != '0) &&
                            (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD);
        end else begin : g_no_lw_m
            assign w_lw_m = 1'b0;
        end
    endgenerate

    assign w_lwstall = w_lw_e | w_lw_m;

    // --------------------------------------------------------- stall / flush
    // Priority: pending exception > memory freeze > new exception > hazards.
    always_comb begin
        w_stallF   = 1'b0;
        w_stallD   = 1'b0;
        w_stallE   = 1'b0;
        w_stallM   = 1'b0;
        w_stallW   = 1'b0;
        w_flushD   = 1'b0;
        w_flushE   = 1'b0;
        w_flushM   = 1'b0;
        w_flushW   = 1'b0;
        w_redirect = 1'b0;
        w_newpc    = '0;

        if (w_wait && !w_mem_busy) begin
            w_flushD   = 1'b1;
            w_flushE   = 1'b1;
            w_flushM   = 1'b1;
            w_flushW   = 1'b1;
            w_redirect = 1'b1;
            w_newpc    = r_pend_pc;
        end else if (w_mem_busy) begin
            w_stallF = 1'b1;
            w_stallD = 1'b1;
            w_stallE = 1'b1;
            w_stallM = 1'b1;
            w_stallW = 1'b1;
        end else if (hz.except_logicM) begin
            w_flushD   = 1'b1;
            w_flushE   = 1'b1;
            w_flushM   = 1'b1;
            w_flushW   = 1'b1;
            w_redirect = 1'b1;
            w_newpc    = w_exc_target;
        end else begin
            // A taken branch in M overrides the divider's fetch stall; the
            // E stage holds the divide, so it is neither bubbled nor flushed.
            w_stallF = w_lwstall | (hz.stall_divE & ~hz.branch_takenM);
            w_stallD = w_lwstall | hz.stall_divE;
            w_stallE = hz.stall_divE;
            w_flushD = hz.branch_takenM;
            w_flushE = (w_lwstall | hz.branch_takenM) & ~hz.stall_divE;
            w_flushM = hz.stall_divE;
        end
    end

    // -------------------------------------------------- exception FSM / counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_pend_pc      <= '0;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (hz.except_logicM && w_mem_busy) begin
                        r_pend_pc <= w_exc_target;
                        r_state   <= ST_WAIT_MEM;
                    end
                end
                ST_WAIT_MEM: begin
                    if (!w_mem_busy)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase

            if (w_stallF && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------- outputs
    assign hz.stallF       = w_stallF;
    assign hz.stallD       = w_stallD;
    assign hz.stallE       = w_stallE;
    assign hz.stallM       = w_stallM;
    assign hz.stallW       = w_stallW;
    assign hz.flushD       = w_flushD;
    assign hz.flushE       = w_flushE;
    assign hz.flushM       = w_flushM;
    assign hz.flushW       = w_flushW;
    assign hz.forwardaE    = w_fwdaE;
    assign hz.forwardbE    = w_fwdbE;
    assign hz.forwardaD    = w_fwdaD;
    assign hz.forwardbD    = w_fwdbD;
    assign hz.pc_redirect  = w_redirect;
    assign hz.newpc        = w_newpc;
    assign hz.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
module tb_hazard_ctrl_v2;

    typedef struct packed {
        logic        i_stall, d_stall;
        logic [4:0]  rsD, rtD, rsE, rtE;
        logic [4:0]  writeregE, writeregM, writeregW;
        logic        regwriteE, regwriteM, regwriteW;
        logic        memtoregE, memtoregM;
        logic        stall_divE, branch_takenM, except_logicM;
        logic [31:0] excepttypeM, cp0_epcM;
    } vec_t;

    // stall = {F,D,E,M,W}, flush = {D,E,M,W}
    typedef struct packed {
        logic [4:0]  stall;
        logic [3:0]  flush;
        logic [1:0]  fa, fb;
        logic        fad, fbd;
        logic        redir;
        logic [31:0] npc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t v   = '0;
    int   nvec  = 0;
    int   nfail = 0;
    bit   chk_en = 1'b0;

    // bench-side reference state
    bit          m_pend = 1'b0;
    logic [31:0] m_ppc  = '0;
    longint      m_cnt1 = 0;
    longint      m_cnt2 = 0;

    always #5 clk = ~clk;

    hazard_ctrl_v2_if #(.RAW(5), .CNT_W(32)) bus1 ();
    hazard_ctrl_v2_if #(.RAW(5), .CNT_W(4))  bus2 ();

    hazard_ctrl_v2 #(.RAW(5), .EXC_VEC(32'hBFC00380), .LOAD_LAT(1), .CNT_W(32))
        dut1 (.clk(clk), .rst(rst), .hz(bus1));
    hazard_ctrl_v2 #(.RAW(5), .EXC_VEC(32'hBFC00380), .LOAD_LAT(2), .CNT_W(4))
        dut2 (.clk(clk), .rst(rst), .hz(bus2));

    assign bus1.i_stall = v.i_stall;             assign bus2.i_stall = v.i_stall;
    assign bus1.d_stall = v.d_stall;             assign bus2.d_stall = v.d_stall;
    assign bus1.rsD = v.rsD;                     assign bus2.rsD = v.rsD;
    assign bus1.rtD = v.rtD;                     assign bus2.rtD = v.rtD;
    assign bus1.rsE = v.rsE;                     assign bus2.rsE = v.rsE;
    assign bus1.rtE = v.rtE;                     assign bus2.rtE = v.rtE;
    assign bus1.writeregE = v.writeregE;         assign bus2.writeregE = v.writeregE;
    assign bus1.writeregM = v.writeregM;         assign bus2.writeregM = v.writeregM;
    assign bus1.writeregW = v.writeregW;         assign bus2.writeregW = v.writeregW;
    assign bus1.regwriteE = v.regwriteE;         assign bus2.regwriteE = v.regwriteE;
    assign bus1.regwriteM = v.regwriteM;         assign bus2.regwriteM = v.regwriteM;
    assign bus1.regwriteW = v.regwriteW;         assign bus2.regwriteW = v.regwriteW;
    assign bus1.memtoregE = v.memtoregE;         assign bus2.memtoregE = v.memtoregE;
    assign bus1.memtoregM = v.memtoregM;         assign bus2.memtoregM = v.memtoregM;
    assign bus1.stall_divE = v.stall_divE;       assign bus2.stall_divE = v.stall_divE;
    assign bus1.branch_takenM = v.branch_takenM; assign bus2.branch_takenM = v.branch_takenM;
    assign bus1.except_logicM = v.except_logicM; assign bus2.except_logicM = v.except_logicM;
    assign bus1.excepttypeM = v.excepttypeM;     assign bus2.excepttypeM = v.excepttypeM;
    assign bus1.cp0_epcM = v.cp0_epcM;           assign bus2.cp0_epcM = v.cp0_epcM;

    // ------------------------------------------------------------ reference
    function automatic logic [1:0] fwd_e(input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (v.regwriteM && r == v.writeregM) return 2'b10;
        if (v.regwriteW && r == v.writeregW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic needs(input logic [4:0] r);
        return (r != 0) && (r == v.rsD || r == v.rtD);
    endfunction

    function automatic exp_t model(input int lat);
        exp_t e = '0;
        logic busy = v.i_stall | v.d_stall;
        logic [31:0] tgt = (v.excepttypeM == 32'h0E) ? v.cp0_epcM : 32'hBFC00380;
        logic lw = v.memtoregE && v.regwriteE && needs(v.writeregE);
        logic dv = v.stall_divE;
        logic br = v.branch_takenM;
        if (lat == 2) lw = lw | (v.memtoregM && needs(v.writeregM));
        e.fa  = fwd_e(v.rsE);
        e.fb  = fwd_e(v.rtE);
        e.fad = (v.rsD != 0) && v.rsD == v.writeregM && v.regwriteM && !v.memtoregM;
        e.fbd = (v.rtD != 0) && v.rtD == v.writeregM && v.regwriteM && !v.memtoregM;
        if (m_pend && !rst && !busy) begin
            e.flush = 4'hF; e.redir = 1'b1; e.npc = m_ppc;
        end else if (busy) begin
            e.stall = 5'h1F;
        end else if (v.except_logicM) begin
            e.flush = 4'hF; e.redir = 1'b1; e.npc = tgt;
        end else begin
            e.stall = {lw | (dv & ~br), lw | dv, dv, 2'b00};
            e.flush = {br, (lw | br) & ~dv, dv, 1'b0};
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e1, e2;
        e1 = model(1);
        e2 = model(2);
        if (rst) begin
            m_pend <= 1'b0; m_cnt1 <= 0; m_cnt2 <= 0;
        end else begin
            if (!m_pend && v.except_logicM && (v.i_stall | v.d_stall)) begin
                m_pend <= 1'b1;
                m_ppc  <= (v.excepttypeM == 32'h0E) ? v.cp0_epcM : 32'hBFC00380;
            end else if (m_pend && !(v.i_stall | v.d_stall)) begin
                m_pend <= 1'b0;
            end
            if (e1.stall[4] && m_cnt1 < 64'hFFFF_FFFF) m_cnt1 <= m_cnt1 + 1;
            if (e2.stall[4] && m_cnt2 < 15) m_cnt2 <= m_cnt2 + 1;
        end
    end

    function automatic exp_t act1();
        return {bus1.stallF, bus1.stallD, bus1.stallE, bus1.stallM, bus1.stallW,
                bus1.flushD, bus1.flushE, bus1.flushM, bus1.flushW,
                bus1.forwardaE, bus1.forwardbE, bus1.forwardaD, bus1.forwardbD,
                bus1.pc_redirect, bus1.newpc};
    endfunction

    function automatic exp_t act2();
        return {bus2.stallF, bus2.stallD, bus2.stallE, bus2.stallM, bus2.stallW,
                bus2.flushD, bus2.flushE, bus2.flushM, bus2.flushW,
                bus2.forwardaE, bus2.forwardbE, bus2.forwardaD, bus2.forwardbD,
                bus2.pc_redirect, bus2.newpc};
    endfunction

    // per-cycle compare against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t a1, a2, e1, e2;
            a1 = act1(); a2 = act2(); e1 = model(1); e2 = model(2);
            nvec = nvec + 4;
            if (a1 !== e1) begin
                nfail++;
                $display("FAIL ctrl_lat1 t=%0t actual=%h required=%h", $time, a1, e1);
            end
            if (a2 !== e2) begin
                nfail++;
                $display("FAIL ctrl_lat2 t=%0t actual=%h required=%h", $time, a2, e2);
            end
            if (64'(bus1.stall_cycles) !== m_cnt1) begin
                nfail++;
                $display("FAIL cnt32 t=%0t actual=%0d required=%0d", $time, bus1.stall_cycles, m_cnt1);
            end
            if (64'(bus2.stall_cycles) !== m_cnt2) begin
                nfail++;
                $display("FAIL cnt4 t=%0t actual=%0d required=%0d", $time, bus2.stall_cycles, m_cnt2);
            end
        end
    end

    // ---------------------------------------------------------- directed
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; v = '0;
        adv(); adv();
        chk_en = 1'b1;
        rst = 1'b0;

        // reset state, idle inputs
        settle();
        chk("reset_outputs", 64'(act1()), 64'(exp_t'('0)));
        chk("reset_cnt", 64'(bus1.stall_cycles), 64'd0);
        adv();

        // E forwarding: M beats W; r0 never forwards; W only
        v.rsE = 3; v.writeregM = 3; v.regwriteM = 1; v.writeregW = 3; v.regwriteW = 1;
        settle(); chk("fwdaE_M", 64'(bus1.forwardaE), 64'b10); adv();
        v.rsE = 0;
        settle(); chk("fwdaE_r0", 64'(bus1.forwardaE), 64'b00); adv();
        v.rtE = 3; v.regwriteM = 0;
        settle(); chk("fwdbE_W", 64'(bus1.forwardbE), 64'b01); adv();

        // D forwarding from M, suppressed for loads
        v = '0; v.rsD = 4; v.writeregM = 4; v.regwriteM = 1;
        settle(); chk("fwdaD", 64'(bus1.forwardaD), 64'd1); adv();
        v.memtoregM = 1;
        settle(); chk("fwdaD_load", 64'(bus1.forwardaD), 64'd0); adv();

        // load-use: one bubble at LOAD_LAT=1, two at LOAD_LAT=2
        v = '0; v.writeregE = 5; v.memtoregE = 1; v.regwriteE = 1; v.rtD = 5;
        settle();
        chk("lw1_stallF_D_flushE", {61'd0, bus1.stallF, bus1.stallD, bus1.flushE}, 64'b111);
        adv();
        v = '0; v.writeregM = 5; v.memtoregM = 1; v.regwriteM = 1; v.rtD = 5;
        settle();
        chk("lw1_released", 64'(bus1.stallF), 64'd0);
        chk("lw2_second_bubble", {61'd0, bus2.stallF, bus2.stallD, bus2.flushE}, 64'b111);
        adv();

        // exception with idle bus: immediate redirect to EPC
        v = '0; v.except_logicM = 1; v.excepttypeM = 32'h0E; v.cp0_epcM = 32'h80001000;
        settle();
        chk("exc_redirect", 64'(bus1.pc_redirect), 64'd1);
        chk("exc_newpc", 64'(bus1.newpc), 64'h80001000);
        chk("exc_flush", {bus1.flushD, bus1.flushE, bus1.flushM, bus1.flushW}, 64'hF);
        adv();

        // exception under d_stall: 3 frozen cycles, redirect on the 4th only
        v = '0; v.except_logicM = 1; v.excepttypeM = 32'h04; v.d_stall = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("wait_freeze", {62'd0, bus1.stallF, bus1.pc_redirect}, 64'b10);
            adv();
            // a new exception while waiting must not replace the saved target
            v.excepttypeM = 32'h0E; v.cp0_epcM = 32'h12345678;
        end
        v = '0;
        settle();
        chk("wait_redirect", 64'(bus1.pc_redirect), 64'd1);
        chk("wait_newpc", 64'(bus1.newpc), 64'hBFC00380);
        adv();
        settle(); chk("redirect_pulse", 64'(bus1.pc_redirect), 64'd0); adv();

        // divider with taken branch
        v = '0; v.stall_divE = 1; v.branch_takenM = 1;
        settle();
        chk("div_br", {60'd0, bus1.stallF, bus1.flushD, bus1.flushE, bus1.flushM}, 64'b0101);
        adv();

        // stall counter saturation (4-bit instance)
        v = '0; rst = 1; adv(); rst = 0;
        v.i_stall = 1;
        for (int i = 0; i < 20; i++) adv();
        v = '0;
        settle();
        chk("cnt32_20", 64'(bus1.stall_cycles), 64'd20);
        chk("cnt4_sat", 64'(bus2.stall_cycles), 64'd15);
        adv();

        // reset while waiting on memory drops the pending redirect
        v = '0; v.except_logicM = 1; v.excepttypeM = 32'h04; v.d_stall = 1;
        adv();
        v = '0; v.d_stall = 1; rst = 1;
        adv();
        rst = 0; v = '0;
        settle();
        chk("rst_drop_redirect", 64'(bus1.pc_redirect), 64'd0);
        adv();
        adv();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
